// File: rtl/indirect_walker.sv
// indirect_walker: multi-level indirection adapter between the pipeline MEM
// stage (P_ side) and the data memory / D-cache (D_ side).
// A request dereferences up to MAX_LEVELS pointers, starting at P_mem_address.
// It then performs the final read or write at the resolved address.
//
// State table
//   state   | meaning
//   IDLE    | waiting for a request; request fields latched on acceptance
//   PTR     | fetching the next pointer from cur_addr (read, full mask)
//   FINAL   | final read/write at the resolved address
//   RESP    | one-cycle completion pulse to the pipeline
//
// Ports
//   clk, reset_n            clock, async active-low reset
//   P_mem_read/write        pipeline request strobes (held until P_mem_resp)
//   P_mem_address/wdata     initial address, final write data
//   P_mem_byte_enable       byte mask for the final access
//   P_levels                dereference count (0 = direct), clamped to MAX_LEVELS
//   P_mem_resp/rdata/busy   completion pulse, registered read data, busy flag
//   D_mem_*                 downstream memory request / response
module indirect_walker #(
  parameter int WORD_W     = 16,
  parameter int MASK_W     = 2,
  parameter int MAX_LEVELS = 2,
  parameter int ALIGN_PTR  = 1,
  localparam int LVL_W     = $clog2(MAX_LEVELS + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              P_mem_read,
  input  logic              P_mem_write,
  input  logic [WORD_W-1:0] P_mem_address,
  input  logic [WORD_W-1:0] P_mem_wdata,
  input  logic [MASK_W-1:0] P_mem_byte_enable,
  input  logic [LVL_W-1:0]  P_levels,
  output logic              P_mem_resp,
  output logic [WORD_W-1:0] P_mem_rdata,
  output logic              P_busy,
  output logic              D_mem_read,
  output logic              D_mem_write,
  output logic [WORD_W-1:0] D_mem_address,
  output logic [WORD_W-1:0] D_mem_wdata,
  output logic [MASK_W-1:0] D_mem_byte_enable,
  input  logic              D_mem_resp,
  input  logic [WORD_W-1:0] D_mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_PTR, S_FINAL, S_RESP} state_t;

  state_t              state_q, state_d;
  logic                op_write_q, op_write_d;
  logic [WORD_W-1:0]   cur_addr_q, cur_addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [MASK_W-1:0]   be_q, be_d;
  logic [LVL_W-1:0]    lvl_q, lvl_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;

  logic [LVL_W-1:0]    lvl_req;
  logic [WORD_W-1:0]   ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      op_write_q <= 1'b0;
      cur_addr_q <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      lvl_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      op_write_q <= op_write_d;
      cur_addr_q <= cur_addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      lvl_q      <= lvl_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    op_write_d        = op_write_q;
    cur_addr_d        = cur_addr_q;
    wdata_d           = wdata_q;
    be_d              = be_q;
    lvl_d             = lvl_q;
    rdata_d           = rdata_q;
    P_mem_resp        = 1'b0;
    D_mem_read        = 1'b0;
    D_mem_write       = 1'b0;
    D_mem_address     = '0;
    D_mem_wdata       = '0;
    D_mem_byte_enable = '0;

    lvl_req = (P_levels > LVL_W'(MAX_LEVELS)) ? LVL_W'(MAX_LEVELS) : P_levels;

    // Fetched pointers are used verbatim apart from optional word alignment.
    ptr = D_mem_rdata;
    if (ALIGN_PTR != 0) ptr[0] = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (P_mem_read || P_mem_write) begin
          op_write_d = P_mem_write;  // write wins when both strobes are high
          cur_addr_d = P_mem_address;
          wdata_d    = P_mem_wdata;
          be_d       = P_mem_byte_enable;
          lvl_d      = lvl_req;
          state_d    = (lvl_req != '0) ? S_PTR : S_FINAL;
        end
      end
      S_PTR: begin
        D_mem_read        = 1'b1;
        D_mem_address     = cur_addr_q;
        D_mem_byte_enable = '1;
        if (D_mem_resp) begin
          cur_addr_d = ptr;
          lvl_d      = lvl_q - LVL_W'(1);
          if (lvl_q == LVL_W'(1)) state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        D_mem_read        = !op_write_q;
        D_mem_write       = op_write_q;
        D_mem_address     = cur_addr_q;
        D_mem_wdata       = wdata_q;
        D_mem_byte_enable = be_q;
        if (D_mem_resp) begin
          if (!op_write_q) rdata_d = D_mem_rdata;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        P_mem_resp = 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign P_busy      = (state_q != S_IDLE);
  assign P_mem_rdata = rdata_q;

endmodule

// File: tb/tb_indirect_walker.sv
module tb_indirect_walker;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        P_mem_read, P_mem_write;
  logic [15:0] P_mem_address, P_mem_wdata;
  logic [1:0]  P_mem_byte_enable;
  logic [1:0]  P_levels;
  logic        P_mem_resp, P_busy;
  logic [15:0] P_mem_rdata;
  logic        D_mem_read, D_mem_write;
  logic [15:0] D_mem_address, D_mem_wdata;
  logic [1:0]  D_mem_byte_enable;
  logic        D_mem_resp;
  logic [15:0] D_mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  indirect_walker #(.WORD_W(16), .MASK_W(2), .MAX_LEVELS(2), .ALIGN_PTR(1)) dut (
    .clk(clk), .reset_n(reset_n),
    .P_mem_read(P_mem_read), .P_mem_write(P_mem_write),
    .P_mem_address(P_mem_address), .P_mem_wdata(P_mem_wdata),
    .P_mem_byte_enable(P_mem_byte_enable), .P_levels(P_levels),
    .P_mem_resp(P_mem_resp), .P_mem_rdata(P_mem_rdata), .P_busy(P_busy),
    .D_mem_read(D_mem_read), .D_mem_write(D_mem_write),
    .D_mem_address(D_mem_address), .D_mem_wdata(D_mem_wdata),
    .D_mem_byte_enable(D_mem_byte_enable),
    .D_mem_resp(D_mem_resp), .D_mem_rdata(D_mem_rdata)
  );

  // Downstream memory: responds on the k-th cycle of a strobe and logs each access.
  logic [15:0] mem [0:65535];
  int          cur_k = 1;
  int          wcnt = 0;
  int          log_n = 0;
  logic [15:0] log_addr [0:15];
  logic [15:0] log_wdata [0:15];
  logic [1:0]  log_be [0:15];
  logic        log_wr [0:15];
  int          resp_strobe_err = 0;

  always @(negedge clk) begin
    if (!reset_n) begin
      wcnt = 0;
      D_mem_resp = 1'b0;
    end else if (D_mem_read || D_mem_write) begin
      wcnt++;
      if (wcnt == cur_k) begin
        wcnt = 0;
        D_mem_resp = 1'b1;
        D_mem_rdata = mem[D_mem_address];
        if (D_mem_write) begin
          if (D_mem_byte_enable[0]) mem[D_mem_address][7:0]  = D_mem_wdata[7:0];
          if (D_mem_byte_enable[1]) mem[D_mem_address][15:8] = D_mem_wdata[15:8];
        end
        if (log_n < 16) begin
          log_addr[log_n]  = D_mem_address;
          log_wdata[log_n] = D_mem_wdata;
          log_be[log_n]    = D_mem_byte_enable;
          log_wr[log_n]    = D_mem_write;
        end
        log_n++;
      end else begin
        D_mem_resp = 1'b0;
      end
    end else begin
      wcnt = 0;
      D_mem_resp = 1'b0;
    end
    if (P_mem_resp && (D_mem_read || D_mem_write)) resp_strobe_err++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  lv;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    int          k;
    logic [15:0] exp_rdata;
    int          exp_cyc;
    int          exp_nacc;
    logic [15:0] exp_a0;
    logic [15:0] exp_a1;
    logic [15:0] exp_alast;
    logic [1:0]  exp_belast;
    logic        exp_wrlast;
  } vec_t;

  vec_t vecs [0:7];

  // Issue one request, scramble the P_ fields after acceptance, and check
  // latency, response data and the logged downstream accesses.
  task automatic run_vec(input vec_t v, input string tag);
    int cyc;
    int resp_cyc;
    bit got;
    @(posedge clk); #1;
    cur_k = v.k;
    log_n = 0;
    P_mem_read = v.rd;
    P_mem_write = v.wr;
    P_levels = v.lv;
    P_mem_address = v.addr;
    P_mem_wdata = v.wdata;
    P_mem_byte_enable = v.be;
    cyc = 0;
    resp_cyc = -1;
    got = 0;
    while (!got && cyc < 200) begin
      @(negedge clk);
      if (cyc == 1) begin
        chk({tag, " busy"}, {31'd0, P_busy}, 32'd1);
        P_mem_address = 16'hFFFF;
        P_mem_wdata = 16'hFFFF;
        P_mem_byte_enable = 2'b00;
        P_levels = 2'd0;
      end
      if (P_mem_resp) begin
        got = 1;
        resp_cyc = cyc;
        P_mem_read = 1'b0;
        P_mem_write = 1'b0;
      end else begin
        @(posedge clk);
        cyc++;
      end
    end
    chk({tag, " resp_cycle"}, resp_cyc, v.exp_cyc);
    chk({tag, " rdata"}, {16'd0, P_mem_rdata}, {16'd0, v.exp_rdata});
    chk({tag, " n_access"}, log_n, v.exp_nacc);
    chk({tag, " addr0"}, {16'd0, log_addr[0]}, {16'd0, v.exp_a0});
    if (v.exp_nacc >= 2) chk({tag, " addr1"}, {16'd0, log_addr[1]}, {16'd0, v.exp_a1});
    for (int i = 0; i < log_n - 1 && i < 15; i++) begin
      chk({tag, " ptr_mask"}, {30'd0, log_be[i]}, 32'h3);
      chk({tag, " ptr_is_read"}, {31'd0, log_wr[i]}, 32'd0);
    end
    if (log_n >= 1 && log_n <= 16) begin
      chk({tag, " last_addr"}, {16'd0, log_addr[log_n-1]}, {16'd0, v.exp_alast});
      chk({tag, " last_mask"}, {30'd0, log_be[log_n-1]}, {30'd0, v.exp_belast});
      chk({tag, " last_is_write"}, {31'd0, log_wr[log_n-1]}, {31'd0, v.exp_wrlast});
      if (v.exp_wrlast) chk({tag, " last_wdata"}, {16'd0, log_wdata[log_n-1]}, {16'd0, v.wdata});
    end
    @(posedge clk);
    @(negedge clk);
    chk({tag, " resp_one_cycle"}, {31'd0, P_mem_resp}, 32'd0);
    chk({tag, " idle_after"}, {31'd0, P_busy}, 32'd0);
  endtask

  initial begin
    int pulses;
    int p_cyc [0:3];
    int resp_in_reset;

    reset_n = 1'b0;
    P_mem_read = 1'b0;
    P_mem_write = 1'b0;
    P_mem_address = '0;
    P_mem_wdata = '0;
    P_mem_byte_enable = '0;
    P_levels = '0;
    D_mem_resp = 1'b0;
    D_mem_rdata = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0040] = 16'h1234;
    mem[16'h0100] = 16'h0200;
    mem[16'h0200] = 16'hBEEF;
    mem[16'h0010] = 16'h0021;
    mem[16'h0020] = 16'h0300;
    mem[16'h0300] = 16'h5500;
    mem[16'h0400] = 16'h0500;
    mem[16'h0500] = 16'h0601;
    mem[16'h0600] = 16'hCAFE;
    mem[16'hBEEE] = 16'h7777;

    //            rd  wr  lv    addr      wdata     be     k  rdata     cyc nacc a0        a1        alast     be_l   wr_l
    vecs[0] = '{1'b1, 1'b0, 2'd0, 16'h0040, 16'h0000, 2'b11, 1, 16'h1234, 2, 1, 16'h0040, 16'h0000, 16'h0040, 2'b11, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 2'd1, 16'h0100, 16'h0000, 2'b11, 2, 16'hBEEF, 5, 2, 16'h0100, 16'h0200, 16'h0200, 2'b11, 1'b0};
    vecs[2] = '{1'b0, 1'b1, 2'd2, 16'h0010, 16'h00AA, 2'b01, 1, 16'hBEEF, 4, 3, 16'h0010, 16'h0020, 16'h0300, 2'b01, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 2'd0, 16'h0300, 16'h0000, 2'b11, 3, 16'h55AA, 4, 1, 16'h0300, 16'h0000, 16'h0300, 2'b11, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 2'd3, 16'h0400, 16'h0000, 2'b11, 1, 16'hCAFE, 4, 3, 16'h0400, 16'h0500, 16'h0600, 2'b11, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 2'd2, 16'h0100, 16'h0000, 2'b11, 2, 16'h7777, 7, 3, 16'h0100, 16'h0200, 16'hBEEE, 2'b11, 1'b0};
    vecs[6] = '{1'b1, 1'b1, 2'd0, 16'h0700, 16'h1357, 2'b10, 1, 16'h7777, 2, 1, 16'h0700, 16'h0000, 16'h0700, 2'b10, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 2'd0, 16'h0700, 16'h0000, 2'b11, 2, 16'h1300, 3, 1, 16'h0700, 16'h0000, 16'h0700, 2'b11, 1'b0};

    repeat (2) @(negedge clk);
    chk("rst P_mem_resp", {31'd0, P_mem_resp}, 32'd0);
    chk("rst P_busy", {31'd0, P_busy}, 32'd0);
    chk("rst P_mem_rdata", {16'd0, P_mem_rdata}, 32'd0);
    chk("rst D_mem_read", {31'd0, D_mem_read}, 32'd0);
    chk("rst D_mem_write", {31'd0, D_mem_write}, 32'd0);
    chk("rst D_mem_address", {16'd0, D_mem_address}, 32'd0);
    chk("rst D_mem_wdata", {16'd0, D_mem_wdata}, 32'd0);
    chk("rst D_mem_byte_enable", {30'd0, D_mem_byte_enable}, 32'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of a pointer fetch.
    @(posedge clk); #1;
    cur_k = 3;
    P_mem_read = 1'b1;
    P_levels = 2'd2;
    P_mem_address = 16'h0100;
    @(negedge clk);
    @(negedge clk);
    chk("midptr D_mem_read", {31'd0, D_mem_read}, 32'd1);
    chk("midptr D_mem_address", {16'd0, D_mem_address}, 32'h0100);
    reset_n = 1'b0;
    #1;
    chk("rstmid D_mem_read", {31'd0, D_mem_read}, 32'd0);
    chk("rstmid P_busy", {31'd0, P_busy}, 32'd0);
    chk("rstmid D_mem_address", {16'd0, D_mem_address}, 32'd0);
    P_mem_read = 1'b0;
    resp_in_reset = 0;
    repeat (3) begin
      @(negedge clk);
      if (P_mem_resp) resp_in_reset++;
    end
    chk("rstmid no_resp", resp_in_reset, 0);
    chk("rstmid P_mem_rdata", {16'd0, P_mem_rdata}, 32'd0);
    reset_n = 1'b1;
    run_vec(vecs[0], "post_rst");

    // Back-to-back direct reads with P_mem_read held high.
    @(posedge clk); #1;
    cur_k = 1;
    P_mem_read = 1'b1;
    P_levels = 2'd0;
    P_mem_address = 16'h0040;
    P_mem_byte_enable = 2'b11;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (P_mem_resp) begin
        if (pulses < 4) p_cyc[pulses] = c;
        pulses++;
      end
      if (c == 3) chk("b2b idle_between", {31'd0, P_busy}, 32'd0);
      if (c == 5) P_mem_read = 1'b0;
      @(posedge clk);
    end
    chk("b2b pulses", pulses, 2);
    if (pulses >= 2) begin
      chk("b2b first_pulse", p_cyc[0], 2);
      chk("b2b second_pulse", p_cyc[1], 5);
    end
    chk("b2b rdata", {16'd0, P_mem_rdata}, 32'h1234);
    chk("no strobe during RESP", resp_strobe_err, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/indirect_walker.md
Name: indirect_walker

Overview:
- Parametrised multi-level indirection adapter between the pipeline MEM stage (P_ side) and the data memory / D-cache (D_ side).
- Each request carries a level count. The block performs that many pointer dereferences, then the final read or write at the resolved address.
- Generalises the single-level LDI/STI adapter: N-level chains, a correct indirect write (STI) at the resolved address, latched request fields, and registered response data.

Parameters:
- WORD_W, 16, data and address width in bits.
- MASK_W, 2, byte-enable width (WORD_W/8).
- MAX_LEVELS, 2, maximum pointer dereferences per request (>=1).
- ALIGN_PTR, 1, when 1, bit 0 of every fetched pointer is forced to 0 (word-aligned).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- P_mem_read  in  1  read request, held high until P_mem_resp.
- P_mem_write  in  1  write request, held high until P_mem_resp.
- P_mem_address  in  WORD_W  initial address.
- P_mem_wdata  in  WORD_W  write data for the final access.
- P_mem_byte_enable  in  MASK_W  byte mask for the final access.
- P_levels  in  $clog2(MAX_LEVELS+1)  number of dereferences, 0 = direct access.
- P_mem_resp  out  1  one-cycle completion pulse.
- P_mem_rdata  out  WORD_W  final read data, registered.
- P_busy  out  1  high from request acceptance until P_mem_resp.
- D_mem_read  out  1  downstream read.
- D_mem_write  out  1  downstream write.
- D_mem_address  out  WORD_W  downstream address.
- D_mem_wdata  out  WORD_W  downstream write data.
- D_mem_byte_enable  out  MASK_W  downstream byte mask.
- D_mem_resp  in  1  downstream completion, one cycle.
- D_mem_rdata  in  WORD_W  downstream read data, valid with D_mem_resp.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all internal registers cleared.
  - P_mem_resp=0, P_busy=0, P_mem_rdata=0.
  - D_mem_read=0, D_mem_write=0, D_mem_address=0, D_mem_wdata=0, D_mem_byte_enable=0.
- Reset mid-operation: abandons the transaction immediately; no P_mem_resp is produced. The downstream is expected to be reset together with this block.
- Outputs are decoded from state and registers only; there is no P_→D_ combinational path.
- IDLE:
  - D_ read/write=0; P_busy=0.
  - If P_mem_read|P_mem_write: latch op (write wins if both high), address→cur_addr, wdata, byte_enable, and lvl=min(P_levels, MAX_LEVELS).
  - Go to PTR if lvl>0, else FINAL.
  - D_mem_resp in IDLE is ignored.
- PTR:
  - D_mem_read=1, D_mem_write=0, D_mem_address=cur_addr, D_mem_byte_enable=all ones.
  - On D_mem_resp: cur_addr<=D_mem_rdata (bit 0 cleared if ALIGN_PTR) and lvl<=lvl-1.
  - Next state: FINAL if lvl==1, else remain in PTR.
  - Between consecutive dereferences, D_mem_read stays high and the address changes on the cycle after D_mem_resp.
- FINAL:
  - D_mem_read=!op_write, D_mem_write=op_write, D_mem_address=cur_addr.
  - D_mem_wdata=latched wdata, D_mem_byte_enable=latched mask.
  - On D_mem_resp: P_mem_rdata<=D_mem_rdata (reads only; writes leave it unchanged); go to RESP.
- RESP:
  - P_mem_resp=1 for exactly one cycle; D_ read/write=0; P_busy=1.
  - Go to IDLE. A request sampled in the following IDLE cycle is a new request.
- P_ inputs that change while busy are ignored; only the latched copies are used.
- Latency, with downstream latency k cycles per access (D_mem_resp on the k-th cycle of the strobe):
  - Request seen in cycle 0; first D_ strobe in cycle 1.
  - P_mem_resp in cycle (lvl+1)*k+1.
  - Minimum back-to-back issue is every (lvl+1)*k+2 cycles.
- Pointer-address arithmetic has no wrap handling; fetched pointers are used verbatim (modulo ALIGN_PTR).
- P_levels > MAX_LEVELS is clamped to MAX_LEVELS.

Test Plan:
1. Direct read: P_levels=0, read at 0x0040 (mem=0x1234), k=1 → one D_ read at 0x0040, P_mem_resp in cycle 2, P_mem_rdata=0x1234.
2. LDI, single level: mem[0x0100]=0x0200, mem[0x0200]=0xBEEF, P_levels=1, k=2 → D_ reads at 0x0100 then 0x0200, P_mem_resp in cycle 5, rdata=0xBEEF.
3. STI, two levels with ALIGN_PTR=1:
   - Stimulus: mem[0x0010]=0x0021, mem[0x0020]=0x0300, write wdata=0x00AA, mask=2'b01.
   - Required: reads at 0x0010 and 0x0020 with mask 2'b11, then a write at 0x0300 with mask 2'b01 and wdata 0x00AA; mem[0x0300] low byte=0xAA.
4. Clamp and latch: P_levels=3 with MAX_LEVELS=2, P_mem_address changed to 0xFFFF mid-operation → exactly 2 pointer reads from the original address; the change is ignored.
5. Reset mid-PTR: assert reset_n=0 while D_mem_read=1 → same cycle, D_mem_read=0, P_busy=0, no P_mem_resp; after release, a direct read to 0x0040 completes normally.
6. Back-to-back: two held requests with P_mem_read high continuously → exactly two P_mem_resp pulses, separated by at least one IDLE cycle; no D_ strobe during RESP.
